// File: rtl/feature_out_buffer.sv
// ============================================================================
// Module   : feature_out_buffer
// Purpose  : FWFT output FIFO for pooled features with frame tagging.
//            Frame checksum is built only with FEATURE_OUT_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module feature_out_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32,
   parameter int FRAME_LEN  = 1176
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_feature_valid,
   input  logic [DATA_WIDTH-1:0]      i_feature,
   output logic                       o_valid,
   output logic [DATA_WIDTH-1:0]      o_feature,
   input  logic                       i_ready,
   output logic                       o_last,
   output logic                       o_frame_done,
   output logic                       o_overflow,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic [15:0]                o_checksum
);

   localparam int              AW         = $clog2(DEPTH);
   localparam int              IW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [AW:0]     C_FULL     = (AW+1)'(DEPTH);
   localparam logic [IW-1:0]   C_LAST_IDX = IW'(FRAME_LEN - 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [IW-1:0]         idx;
   logic                  overflow;
   logic                  frame_done;

   logic                  not_empty;
   logic                  push;
   logic                  pop;
   logic                  head_last;

   always_comb begin
      not_empty = (count != '0);
      pop       = not_empty && i_ready;
      // A full FIFO still accepts when the head leaves in the same cycle.
      push      = i_feature_valid && ((count != C_FULL) || pop);
      head_last = not_empty && (idx == C_LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem[wr_ptr] <= i_feature;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         idx        <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (i_feature_valid && !push) begin
            overflow <= 1'b1;
         end
         // Framing follows popped words only; dropped inputs never count.
         if (pop) begin
            idx <= head_last ? '0 : idx + 1'b1;
         end
         frame_done <= pop && head_last;
      end
   end

`ifdef FEATURE_OUT_CHECKSUM_EN
   logic [15:0] acc;
   logic [15:0] checksum;
   logic [15:0] head_low;

   generate
      if (DATA_WIDTH >= 16) begin : g_low_slice
         assign head_low = mem[rd_ptr][15:0];
      end else begin : g_low_sext
         assign head_low = {{(16-DATA_WIDTH){mem[rd_ptr][DATA_WIDTH-1]}}, mem[rd_ptr]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc      <= '0;
         checksum <= '0;
      end else if (pop) begin
         if (head_last) begin
            checksum <= acc + head_low;
            acc      <= '0;
         end else begin
            acc      <= acc + head_low;
         end
      end
   end

   assign o_checksum = rst ? checksum : 16'h0000;
`else
   assign o_checksum = 16'h0000;
`endif

   // Status outputs are forced low while reset is held.
   assign o_valid      = rst && not_empty;
   assign o_feature    = mem[rd_ptr];
   assign o_last       = rst && head_last;
   assign o_frame_done = rst && frame_done;
   assign o_overflow   = rst && overflow;
   assign o_count      = rst ? count : '0;

endmodule

`default_nettype wire

// File: tb/tb_feature_out_buffer.sv
// ============================================================================
// Module   : tb_feature_out_buffer
// Purpose  : Directed vector table plus multi-cycle frame/overflow sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_feature_out_buffer;

   localparam int DW = 16;
   localparam int DP = 32;
   localparam int FL = 1176;
`ifdef FEATURE_OUT_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_feature_valid = 1'b0;
   logic [DW-1:0] i_feature = '0;
   logic          i_ready = 1'b0;
   logic          o_valid;
   logic [DW-1:0] o_feature;
   logic          o_last;
   logic          o_frame_done;
   logic          o_overflow;
   logic [5:0]    o_count;
   logic [15:0]   o_checksum;

   int n_checks = 0;
   int n_fail   = 0;

   feature_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .FRAME_LEN(FL)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_feature_valid(i_feature_valid),
      .i_feature      (i_feature),
      .o_valid        (o_valid),
      .o_feature      (o_feature),
      .i_ready        (i_ready),
      .o_last         (o_last),
      .o_frame_done   (o_frame_done),
      .o_overflow     (o_overflow),
      .o_count        (o_count),
      .o_checksum     (o_checksum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          rst_n;
      logic          fv;
      logic [15:0]   feat;
      logic          rdy;
      logic          e_valid;
      logic          chk_feat;
      logic [15:0]  e_feat;
      logic [5:0]    e_count;
      logic          e_ovf;
   } vec_t;

   vec_t vecs [14];

   task automatic do_reset(input logic fv, input logic rdy);
      rst = 1'b0; i_feature_valid = fv; i_ready = rdy; i_feature = 16'hDEAD;
      @(negedge clk);
      check("rst_valid",      32'(o_valid),      32'd0);
      check("rst_count",      32'(o_count),      32'd0);
      check("rst_overflow",   32'(o_overflow),   32'd0);
      check("rst_frame_done", 32'(o_frame_done), 32'd0);
      check("rst_last",       32'(o_last),       32'd0);
      check("rst_checksum",   32'(o_checksum),   32'd0);
      rst = 1'b1; i_feature_valid = 1'b0; i_ready = 1'b0;
   endtask

   // Scoreboarded streaming with percent-probability valid/ready.
   task automatic stream(input int n_words, input int vpct, input int rpct,
                         input bit ones, output int frames);
      logic [15:0] q[$];
      logic [15:0] sum = '0;
      logic [15:0] cks_exp = '0;
      logic [15:0] d;
      logic [15:0] head;
      int          pushed = 0;
      int          idx = 0;
      int          cyc = 0;
      bit          done_pend = 0;
      bit          do_push;
      bit          rdy;
      frames = 0;
      while (pushed < n_words || q.size() != 0 || done_pend) begin
         if (cyc > n_words * 4 + 200) begin
            check("stream_timeout", 32'd1, 32'd0);
            break;
         end
         check("frame_done", 32'(o_frame_done), 32'(done_pend));
         if (done_pend) begin
            check("checksum", 32'(o_checksum), CK ? 32'(cks_exp) : 32'd0);
            frames++;
         end
         done_pend = 0;
         check("count", 32'(o_count), 32'(q.size()));
         check("valid", 32'(o_valid), 32'(q.size() != 0));
         check("last",  32'(o_last),  32'(q.size() != 0 && idx == FL - 1));
         do_push = (pushed < n_words) && ($urandom_range(0, 99) < vpct);
         rdy     = ($urandom_range(0, 99) < rpct);
         d       = ones ? 16'd1 : 16'($urandom);
         if (rdy && q.size() != 0) begin
            head = q.pop_front();
            check("feature", 32'(o_feature), 32'(head));
            sum = sum + head;
            if (idx == FL - 1) begin
               cks_exp = sum; sum = '0; idx = 0; done_pend = 1;
            end else begin
               idx++;
            end
         end
         if (do_push) begin
            q.push_back(d);
            pushed++;
         end
         i_feature_valid = do_push; i_feature = d; i_ready = rdy;
         @(negedge clk);
         cyc++;
      end
      i_feature_valid = 1'b0; i_ready = 1'b0;
   endtask

   initial begin
      int fr;
      //           rst fv feat      rdy  val chk feat      cnt  ovf
      vecs[0]  = '{0, 0, 16'h0000, 0,   0,  0, 16'h0000, 6'd0, 0};
      vecs[1]  = '{0, 1, 16'h0055, 1,   0,  0, 16'h0000, 6'd0, 0};
      vecs[2]  = '{1, 1, 16'h0001, 1,   1,  1, 16'h0001, 6'd1, 0};
      vecs[3]  = '{1, 1, 16'h0002, 1,   1,  1, 16'h0002, 6'd1, 0};
      vecs[4]  = '{1, 1, 16'h0003, 1,   1,  1, 16'h0003, 6'd1, 0};
      vecs[5]  = '{1, 1, 16'h0004, 1,   1,  1, 16'h0004, 6'd1, 0};
      vecs[6]  = '{1, 1, 16'h0005, 1,   1,  1, 16'h0005, 6'd1, 0};
      vecs[7]  = '{1, 0, 16'h0000, 1,   0,  0, 16'h0000, 6'd0, 0};
      vecs[8]  = '{1, 0, 16'h0000, 1,   0,  0, 16'h0000, 6'd0, 0};
      vecs[9]  = '{1, 1, 16'hFFF9, 0,   1,  1, 16'hFFF9, 6'd1, 0};
      vecs[10] = '{1, 1, 16'h1234, 0,   1,  1, 16'hFFF9, 6'd2, 0};
      vecs[11] = '{1, 0, 16'h0000, 0,   1,  1, 16'hFFF9, 6'd2, 0};
      vecs[12] = '{1, 0, 16'h0000, 1,   1,  1, 16'h1234, 6'd1, 0};
      vecs[13] = '{1, 0, 16'h0000, 1,   0,  0, 16'h0000, 6'd0, 0};

      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         rst = vecs[i].rst_n; i_feature_valid = vecs[i].fv;
         i_feature = vecs[i].feat; i_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].e_count));
         check($sformatf("vec%0d_ovf", i), 32'(o_overflow), 32'(vecs[i].e_ovf));
         check($sformatf("vec%0d_last", i), 32'(o_last), 32'd0);
         if (vecs[i].chk_feat)
            check($sformatf("vec%0d_feat", i), 32'(o_feature), 32'(vecs[i].e_feat));
      end

      // Overflow: fill past depth with the consumer stalled.
      do_reset(1'b0, 1'b0);
      for (int i = 1; i <= DP + 3; i++) begin
         i_feature_valid = 1'b1; i_feature = 16'(i);
         @(negedge clk);
         check("ovf_fill_count", 32'(o_count), (i < DP) ? 32'(i) : 32'(DP));
         check("ovf_flag", 32'(o_overflow), 32'(i > DP));
      end
      i_feature_valid = 1'b0; i_ready = 1'b1;
      for (int i = 1; i <= DP; i++) begin
         check("ovf_pop_feat", 32'(o_feature), 32'(i));
         check("ovf_pop_last", 32'(o_last), 32'd0);
         @(negedge clk);
      end
      check("ovf_drained", 32'(o_count), 32'd0);
      check("ovf_sticky", 32'(o_overflow), 32'd1);

      // Full FIFO with simultaneous push and pop.
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < DP; i++) begin
         i_feature_valid = 1'b1; i_feature = 16'(100 + i);
         @(negedge clk);
      end
      check("full_count", 32'(o_count), 32'(DP));
      for (int k = 0; k < 5; k++) begin
         i_feature_valid = 1'b1; i_feature = 16'(200 + k); i_ready = 1'b1;
         check("full_pp_feat", 32'(o_feature), 32'(100 + k));
         @(negedge clk);
         check("full_pp_count", 32'(o_count), 32'(DP));
         check("full_pp_ovf", 32'(o_overflow), 32'd0);
      end
      i_feature_valid = 1'b0;
      for (int i = 5; i < DP + 5; i++) begin
         check("full_drain_feat", 32'(o_feature), (i < DP) ? 32'(100 + i) : 32'(200 + i - DP));
         @(negedge clk);
      end
      check("full_drain_count", 32'(o_count), 32'd0);
      i_ready = 1'b0;

      // One full frame of ones: last on 1176th pop, checksum 0x0498.
      do_reset(1'b0, 1'b0);
      stream(FL, 100, 100, 1'b1, fr);
      check("frame_ones_frames", 32'(fr), 32'd1);
      check("frame_ones_cksum", 32'(o_checksum), CK ? 32'h0498 : 32'd0);

      // Reset mid-frame, then a full new frame must be framed from index 0.
      do_reset(1'b0, 1'b0);
      stream(600, 100, 100, 1'b1, fr);
      check("midrst_partial_frames", 32'(fr), 32'd0);
      do_reset(1'b1, 1'b1);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_count", 32'(o_count), 32'd0);
      stream(FL, 100, 100, 1'b1, fr);
      check("midrst_frames", 32'(fr), 32'd1);

      // Random traffic over three frames.
      do_reset(1'b0, 1'b0);
      stream(3 * FL, 50, 75, 1'b0, fr);
      check("rand_frames", 32'(fr), 32'd3);
      check("rand_no_overflow", 32'(o_overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/feature_out_buffer.md
FEATURE_OUT_BUFFER -- requirements
Module: feature_out_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the signed feature word.
REQ-002 SHALL have parameter DEPTH, default 32: FIFO entries; power of two, 4..256.
REQ-003 SHALL have parameter FRAME_LEN, default 1176: features per frame (6 ch x 14 x 14 pooled).
REQ-004 SHALL have port clk  in  1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port i_feature_valid  in  1: post-processed feature present this cycle; no backpressure upstream.
REQ-007 SHALL have port i_feature  in  DATA_WIDTH: signed feature word.
REQ-008 SHALL have port o_valid  out  1: head entry available.
REQ-009 SHALL have port o_feature  out  DATA_WIDTH: head entry, stable while o_valid=1 and i_ready=0.
REQ-010 SHALL have port i_ready  in  1: downstream accepts head.
REQ-011 SHALL have port o_last  out  1: head is the final feature of its frame.
REQ-012 SHALL have port o_frame_done  out  1: one-cycle pulse after the last feature of a frame is popped.
REQ-013 SHALL have port o_overflow  out  1: sticky, a feature was dropped.
REQ-014 SHALL have port o_count  out  $clog2(DEPTH)+1: current occupancy.
REQ-015 SHALL have port o_checksum  out  16: frame checksum (see Configuration).

Function
REQ-016 SHALL implement first-word-fall-through FIFO: o_valid = (o_count != 0), o_feature = head entry, combinational from storage.
REQ-017 SHALL push when i_feature_valid=1 and (count<DEPTH, or count==DEPTH with a pop in the same cycle).
REQ-018 SHALL pop when o_valid=1 and i_ready=1; i_ready while o_valid=0 has no effect.
REQ-019 SHALL present a word pushed in cycle N at o_valid/o_feature in cycle N+1; no same-cycle bypass when empty.
REQ-020 SHALL leave count unchanged on simultaneous push and pop; +1 on push only, -1 on pop only.
REQ-021 SHALL drop the input when i_feature_valid=1, count==DEPTH and no pop; set o_overflow=1 the next cycle, held until reset.
REQ-022 SHALL wrap read/write pointers modulo DEPTH without bubbles.
REQ-023 SHALL keep an output index 0..FRAME_LEN-1 incremented per pop; o_last = o_valid && index==FRAME_LEN-1.
REQ-024 SHALL reset the index to 0 on the pop of an o_last word and assert o_frame_done exactly the following cycle.
REQ-025 SHALL not count dropped features in the index; frame framing follows popped words only.
REQ-026 SHALL not change o_feature, o_last or o_count while stalled (o_valid=1, i_ready=0, no push).

Reset
REQ-027 SHALL, on a clk edge with rst=0, clear pointers, count, index, o_overflow, o_frame_done and checksum state; stored data need not clear.
REQ-028 SHALL drive o_valid=0, o_last=0, o_frame_done=0, o_overflow=0, o_count=0, o_checksum=0 during and the cycle after reset.
REQ-029 SHALL discard partial frame contents on reset mid-frame; the next popped word is index 0.
REQ-030 SHALL ignore i_feature_valid and i_ready in any cycle with rst=0.

Configuration
REQ-031 SHALL, with macro FEATURE_OUT_CHECKSUM_EN defined, accumulate a 16-bit wrap-around sum of the low 16 bits of each popped word, loading o_checksum with the complete frame sum (including the last word) in the same cycle o_frame_done asserts, held until the next frame completes; accumulator restarts at 0 per frame.
REQ-032 SHALL, without FEATURE_OUT_CHECKSUM_EN, tie o_checksum to 0 and instantiate no accumulator logic.

Verification
REQ-033 SHALL cover: reset, push 5 words 1..5 with i_ready=1 -> o_feature 1..5 in order, first o_valid one cycle after first push, o_count never exceeds 1.
REQ-034 SHALL cover: i_ready=0, push DEPTH+3 words -> o_count=32, o_overflow=1 after word 33, words 33..35 lost, pops return 1..32.
REQ-035 SHALL cover: full FIFO with simultaneous push and pop -> o_count stays 32, o_overflow stays 0.
REQ-036 SHALL cover: stream 1176 words of value 1 -> o_last only on 1176th pop, o_frame_done next cycle, o_checksum=1176 (0x0498) with macro, 0 without.
REQ-037 SHALL cover: rst=0 after 600 words of a frame -> o_valid=0, o_count=0; next 1176 pops produce o_last on the 1176th.
REQ-038 SHALL cover: random i_ready with 50% valid traffic across 3 frames -> output order matches input, no drops, exactly 3 o_frame_done pulses.
